// File: rtl/ahbl_mem_slave.sv
// AHB-Lite SRAM slave: byte-lane writes, same-cycle write->read forwarding, ERROR on bad size/alignment/range.
// Latency: OKAY data phase = WAIT_STATES+1 cycles, ERROR = 2 cycles; new address phases accepted only while HREADYOUT=1.
module ahbl_mem_slave #(
   parameter int unsigned ADDR_W      = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);
   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [2:0]  WS    = 3'(WAIT_STATES);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WAIT = 3'd1;
   localparam logic [2:0] ST_DONE = 3'd2;
   localparam logic [2:0] ST_ERR1 = 3'd3;
   localparam logic [2:0] ST_ERR2 = 3'd4;

   logic [2:0]        state, state_nxt;
   logic [2:0]        wait_cnt;
   logic              dp_vld, dp_write, dp_err;
   logic [1:0]        dp_size, dp_lane;
   logic [ADDR_W-1:0] dp_idx, haddr_idx, rd_idx;
   logic              accept, addr_err, wr_en, rd_load, fwd;
   logic [3:0]        wr_be;
   logic [31:0]       rd_data;
   logic [31:0]       mem [DEPTH];
   logic              unused_ok;

   assign unused_ok = HTRANS[0];
   assign haddr_idx = HADDR[ADDR_W+1:2];
   assign accept    = HSEL & HREADY & HTRANS[1] & HREADYOUT;

   always_comb begin
      addr_err = 1'b0;
      if (HSIZE > 3'd2)                         addr_err = 1'b1;
      if (HSIZE == 3'd1 && HADDR[0])            addr_err = 1'b1;
      if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00) addr_err = 1'b1;
      // BASE_ADDR is aligned to the window size, so the upper bits alone decide the range
      if ((HADDR >> (ADDR_W + 2)) != (BASE_ADDR >> (ADDR_W + 2))) addr_err = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE, ST_ERR2: begin
            if (!accept)       state_nxt = ST_IDLE;
            else if (addr_err) state_nxt = ST_ERR1;
            else if (WS != 3'd0) state_nxt = ST_WAIT;
            else               state_nxt = ST_IDLE;
         end
         ST_WAIT: if (wait_cnt == 3'd1) state_nxt = ST_DONE;
         ST_ERR1: state_nxt = ST_ERR2;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_be = 4'b1111;
      case (dp_size)
         2'd0:    wr_be = 4'b0001 << dp_lane;
         2'd1:    wr_be = dp_lane[1] ? 4'b1100 : 4'b0011;
         default: wr_be = 4'b1111;
      endcase
   end

   assign wr_en = dp_vld & dp_write & ~dp_err & HREADYOUT;

   // Zero-wait reads load HRDATA at their address edge, possibly while the previous write lands
   assign rd_idx  = (state == ST_WAIT) ? dp_idx : haddr_idx;
   assign rd_load = (state == ST_WAIT && wait_cnt == 3'd1 && !dp_write) ||
                    (accept && !HWRITE && !addr_err && WS == 3'd0);
   assign fwd     = wr_en && (dp_idx == rd_idx);

   always_comb begin
      rd_data = mem[rd_idx];
      for (int b = 0; b < 4; b++)
         if (fwd && wr_be[b]) rd_data[8*b +: 8] = HWDATA[8*b +: 8];
   end

   always_ff @(posedge HCLK) begin
      if (HRESETn && wr_en)
         for (int b = 0; b < 4; b++)
            if (wr_be[b]) mem[dp_idx][8*b +: 8] <= HWDATA[8*b +: 8];
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state     <= ST_IDLE;
         wait_cnt  <= 3'd0;
         dp_vld    <= 1'b0;
         dp_write  <= 1'b0;
         dp_err    <= 1'b0;
         dp_size   <= 2'd0;
         dp_lane   <= 2'd0;
         dp_idx    <= '0;
         HREADYOUT <= 1'b1;
         HRESP     <= 1'b0;
         HRDATA    <= 32'h0;
      end else begin
         state     <= state_nxt;
         HREADYOUT <= !(state_nxt == ST_WAIT || state_nxt == ST_ERR1);
         HRESP     <= (state_nxt == ST_ERR1 || state_nxt == ST_ERR2);
         if (state_nxt == ST_WAIT && state != ST_WAIT) wait_cnt <= WS;
         else if (state == ST_WAIT)                    wait_cnt <= wait_cnt - 3'd1;
         if (HREADYOUT) begin
            dp_vld   <= accept;
            dp_write <= HWRITE;
            dp_err   <= addr_err;
            dp_size  <= HSIZE[1:0];
            dp_lane  <= HADDR[1:0];
            dp_idx   <= haddr_idx;
         end
         if (rd_load) HRDATA <= rd_data;
      end
   end
endmodule

// File: tb/tb_ahbl_mem_slave.sv
// Bench for ahbl_mem_slave: three instances (0, 2 and 3 wait states) on a shared bus, driven by a
// pipelined master; expected responses are queued at address drive and compared at data-phase completion.
module tb_ahbl_mem_slave;
   typedef struct packed {
      logic        hsel;
      logic [1:0]  htrans;
      logic        write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } xfer_t;

   typedef struct packed {
      logic        err;
      logic        rd;
      logic [31:0] rdata;
   } exp_t;

   localparam logic [31:0] MEM_END = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hsel, hwrite;
   logic [31:0] haddr, hwdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        ho   [3];
   logic        resp [3];
   logic [31:0] rdat [3];
   int          cur;
   logic        ho_m, hresp_m;
   logic [31:0] hrdata_m;

   int    n_chk = 0;
   int    n_err = 0;
   xfer_t stim_q [$];
   exp_t  exp_q  [$];
   logic [31:0] model [int];

   always #5 clk = ~clk;

   assign ho_m     = ho[cur];
   assign hresp_m  = resp[cur];
   assign hrdata_m = rdat[cur];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      ahbl_mem_slave #(
         .ADDR_W(10), .BASE_ADDR(32'h0), .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3))
      ) dut (
         .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel && cur == g), .HADDR(haddr),
         .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata),
         .HREADY(ho_m), .HREADYOUT(ho[g]), .HRESP(resp[g]), .HRDATA(rdat[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int ws_of(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
   endfunction

   function automatic void add(input logic s, input logic [1:0] t, input logic w,
                               input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
      xfer_t x;
      x.hsel = s; x.htrans = t; x.write = w; x.size = sz; x.addr = a; x.wdata = d;
      stim_q.push_back(x);
   endfunction

   function automatic void wr(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
      add(1'b1, 2'b10, 1'b1, sz, a, d);
   endfunction

   function automatic void rd(input logic [31:0] a);
      add(1'b1, 2'b10, 1'b0, 3'd2, a, 32'h0);
   endfunction

   function automatic void push_exp(input int k, input xfer_t x);
      exp_t        e;
      int          key;
      logic [31:0] w;
      logic        lane;
      e.err = (x.size > 3'd2) || (x.size == 3'd1 && x.addr[0]) ||
              (x.size == 3'd2 && x.addr[1:0] != 2'b00) || (x.addr >= MEM_END);
      e.rd  = !x.write;
      key   = k * 4096 + int'(x.addr[11:2]);
      w     = model.exists(key) ? model[key] : 32'h0;
      if (!e.err && x.write) begin
         for (int b = 0; b < 4; b++) begin
            lane = (x.size == 3'd2) ||
                   (x.size == 3'd1 && (b / 2) == int'(x.addr[1])) ||
                   (x.size == 3'd0 && b == int'(x.addr[1:0]));
            if (lane) w[8*b +: 8] = x.wdata[8*b +: 8];
         end
         model[key] = w;
      end
      e.rdata = w;
      exp_q.push_back(e);
   endfunction

   task automatic run_batch(input int k, output int busy);
      xfer_t ap, dp;
      logic  ap_v, dp_v, r;
      int    stalls, guard;
      exp_t  e;
      cur = k; busy = 0; ap_v = 0; dp_v = 0; stalls = 0; guard = 0;
      ap = '0; dp = '0;
      while (guard < 400) begin
         r      = ho_m;
         hwdata = (dp_v && dp.write) ? dp.wdata : 32'h0;
         if (dp_v) begin
            e = exp_q[0];
            busy++;
            if (!r) begin
               stalls++;
               chk("resp_stall", hresp_m, e.err);
            end else begin
               void'(exp_q.pop_front());
               chk("resp_done", hresp_m, e.err);
               chk("wait_cycles", stalls, e.err ? 1 : ws_of(k));
               if (e.rd && !e.err) chk("rdata", hrdata_m, e.rdata);
            end
         end else begin
            chk("idle_rdy_resp", {r, hresp_m}, 2'b10);
         end
         if (r) begin
            ap_v = stim_q.size() > 0;
            if (ap_v) begin
               ap = stim_q.pop_front();
               if (ap.hsel && ap.htrans[1]) push_exp(k, ap);
            end
            hsel   = ap_v && ap.hsel;
            htrans = ap_v ? ap.htrans : 2'b00;
            hwrite = ap.write;
            hsize  = ap.size;
            haddr  = ap.addr;
         end
         @(posedge clk); #1;
         guard++;
         if (r) begin
            dp     = ap;
            dp_v   = ap_v && ap.hsel && ap.htrans[1];
            stalls = 0;
         end
         if (!dp_v && stim_q.size() == 0) break;
      end
      if (guard >= 400) chk("batch_timeout", guard, 0);
      hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int busy;
      rst_n = 1'b0; hsel = 1'b0; htrans = 2'b00; hsize = 3'd2; hwrite = 1'b0;
      haddr = 32'h0; hwdata = 32'h0; cur = 0;
      repeat (2) @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
         chk("reset_hreadyout", ho[g], 1'b1);
         chk("reset_hresp", resp[g], 1'b0);
         chk("reset_hrdata", rdat[g], 32'h0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // zero wait states: forwarding of back-to-back write then read, byte and half merges
      wr(3'd2, 32'h10, 32'hDEADBEEF); rd(32'h10);
      wr(3'd2, 32'h10, 32'h11223344); wr(3'd0, 32'h13, 32'hA5000000); rd(32'h10);
      wr(3'd1, 32'h12, 32'h5A5A0000); rd(32'h10);
      run_batch(0, busy);

      for (int i = 0; i < 8; i++) wr(3'd2, 32'h80 + 32'(4 * i), 32'h1000_0000 + 32'(i * 32'h0101));
      run_batch(0, busy);
      for (int i = 0; i < 8; i++) rd(32'h80 + 32'(4 * i));
      run_batch(0, busy);
      chk("throughput_ws0", busy, 8);

      // errors at zero wait: misaligned half, illegal size, then confirm no change
      add(1'b1, 2'b10, 1'b1, 3'd1, 32'h11, 32'hFFFFFFFF);
      add(1'b1, 2'b10, 1'b1, 3'd3, 32'h10, 32'hFFFFFFFF);
      rd(32'h10);
      run_batch(0, busy);

      // non-transfers must not respond or write
      wr(3'd2, 32'h40, 32'hCAFEF00D);
      run_batch(0, busy);
      add(1'b1, 2'b00, 1'b1, 3'd2, 32'h40, 32'h0BAD0BAD);
      add(1'b1, 2'b01, 1'b1, 3'd2, 32'h40, 32'h0BAD0BAD);
      add(1'b0, 2'b10, 1'b1, 3'd2, 32'h40, 32'h0BAD0BAD);
      rd(32'h40);
      run_batch(0, busy);

      // two wait states: pipelined writes and reads, 3 cycles per transfer
      for (int i = 0; i < 8; i++) wr(3'd2, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      run_batch(1, busy);
      for (int i = 0; i < 8; i++) rd(32'h100 + 32'(4 * i));
      run_batch(1, busy);
      chk("throughput_ws2", busy, 24);
      wr(3'd2, 32'h10, 32'h77665544); rd(32'h10);
      wr(3'd0, 32'h11, 32'h0000EE00); rd(32'h10);
      run_batch(1, busy);

      // errors at two wait states stay 2 cycles and leave word 0 alone
      wr(3'd2, 32'h0, 32'h0A0A0A0A);
      run_batch(1, busy);
      wr(3'd2, 32'h02, 32'hFFFFFFFF);
      wr(3'd2, MEM_END, 32'hEEEEEEEE);
      rd(32'h0);
      run_batch(1, busy);

      // reset in the middle of a waited write abandons it
      wr(3'd2, 32'h20, 32'h0BADF00D); rd(32'h20);
      run_batch(2, busy);
      cur = 2;
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h20;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
      chk("write_stalled", ho_m, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_hreadyout", ho_m, 1'b1);
      chk("midrst_hresp", hresp_m, 1'b0);
      chk("midrst_hrdata", hrdata_m, 32'h0);
      rst_n = 1'b1; hwdata = 32'h0;
      @(posedge clk); #1;
      rd(32'h20);
      run_batch(2, busy);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/ahbl_mem_slave.md
# ahbl_mem_slave

Parametrised AHB-Lite slave memory with programmable wait states, byte-lane writes and error responses. It replaces the fixed HRDATA/HREADY stimulus in the IBEX_wrapper system bench, so the core's AHB-Lite master port can fetch, load and store against a real responder. It is also a reusable on-chip SRAM slave behind the SoC AHB decoder.

## Interface
- ADDR_W, 10: word-address bits; depth = 2^ADDR_W 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to 4*2^ADDR_W.
- WAIT_STATES, 0: data-phase stall cycles per OKAY transfer; legal range 0..7.
- HCLK  in  1  system clock.
- HRESETn  in  1  reset; one clock; reset is synchronous and active-low.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  32  transfer byte address.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HSIZE  in  3  0 = byte, 1 = half-word, 2 = word.
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-wide ready; qualifies the address phase.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data.

## Operation
- Accept: HSEL & HREADY & HTRANS[1] at a rising edge. This registers addr, size, write and err flags and starts the data phase.
- IDLE/BUSY or unselected: no data phase; zero-wait OKAY.
- Error conditions (any one):
  - HSIZE > 2.
  - Half-word access with HADDR[0] = 1.
  - Word access with HADDR[1:0] != 0.
  - HADDR outside BASE_ADDR .. BASE_ADDR + 4*2^ADDR_W - 1.
- An errored transfer never writes the array.
- FSM states and transitions:
  - IDLE (HREADYOUT = 1): on accept with an error flag, go to ERR1. On accept with WAIT_STATES > 0, go to WAIT. Otherwise stay in IDLE; the data phase completes in the next cycle.
  - WAIT: count down from WAIT_STATES with HREADYOUT = 0. At count 1, go to DONE.
  - DONE: HREADYOUT = 1, the completing cycle. On a new accept, go to WAIT or ERR1 as above; otherwise go to IDLE.
  - ERR1: HRESP = 1, HREADYOUT = 0. Always go to ERR2.
  - ERR2: HRESP = 1, HREADYOUT = 1. Accept the next address phase exactly as from IDLE.
- Writes:
  - Byte lanes come from HSIZE and addr[1:0]. Byte: lane addr[1:0]. Half: lanes {addr[1],0} and {addr[1],1}. Word: all lanes.
  - The array updates at the edge ending the completing (HREADYOUT = 1) data-phase cycle, using HWDATA from that cycle.
- Reads:
  - HRDATA carries the full 32-bit word; the master selects lanes.
  - HRDATA is valid in the completing cycle and is held until the next read completes.
- Forwarding: a read whose word address matches a write completing in the same cycle returns the newly written bytes merged with the old bytes. This covers back-to-back write then read, including WAIT_STATES = 0.
- Reset:
  - Registers return to reset values and the FSM goes to IDLE.
  - Array contents are not cleared.
  - A transfer in progress when reset asserts is abandoned with no write.

## Timing
- Reset values: HREADYOUT = 1, HRESP = 0, HRDATA = 0, FSM = IDLE, wait counter = 0.
- OKAY latency: the data phase lasts WAIT_STATES + 1 cycles after the address-phase edge. HREADYOUT is low for exactly WAIT_STATES cycles.
- ERROR: always 2 cycles, independent of WAIT_STATES. HRESP stays high through both cycles.
- Pipelining: a new address phase is accepted only in a cycle where HREADYOUT = 1. Address/control sampled while HREADYOUT = 0 is ignored.
- Back-to-back NONSEQ at WAIT_STATES = 0 gives 100% throughput, one transfer per cycle.
- All outputs are registered. There are no combinational paths from inputs to HREADYOUT or HRESP.

## Test plan
- Reset with HRESETn low for 2 edges mid-write (WAIT_STATES = 3) -> HREADYOUT = 1, HRESP = 0, HRDATA = 0; the target word is unchanged.
- WAIT_STATES = 0: word write 32'hDEADBEEF @0x10, then an immediate read @0x10 -> HRDATA = 32'hDEADBEEF in the cycle after the read address phase (forwarding path).
- Byte write 8'hA5 @0x13 over 32'h11223344 @0x10, then read -> 32'hA5223344. Half write 16'h5A5A @0x12 -> 32'h5A5A3344.
- WAIT_STATES = 2: read -> HREADYOUT low for exactly 2 cycles, data on the 3rd. Eight back-to-back NONSEQ reads -> 24 cycles total.
- Word access @0x02, then access @BASE_ADDR + 4*2^ADDR_W -> each gives ERR1 (HRESP = 1, HREADYOUT = 0), then ERR2 (HRESP = 1, HREADYOUT = 1); no array change.
- HTRANS = IDLE and BUSY with HSEL = 1, and NONSEQ with HSEL = 0 -> HREADYOUT stays 1, HRESP = 0, no writes.
